fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It tracks the destination registers of instructions in flight through the EX, MEM and WB stages. It drives the two registered 2-bit selects of the ALU operand `mux_3` instances and raises a stall on load-use hazards. It sits between decode and execute, alongside the ID/EX pipeline register, and directly feeds the `sel` inputs of both operand muxes.

## Interface
- `REG_AW`, 5: register-address width.
- `CNT_W`, 16: width of the stall-cycle performance counter.

- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `dec_valid`  in  1: decode holds a valid instruction.
- `dec_rs1`, `dec_rs2`  in  REG_AW: decode source registers.
- `dec_rs1_used`, `dec_rs2_used`  in  1: the source is actually read.
- `dec_rd`  in  REG_AW: decode destination register.
- `dec_we`  in  1: the decode instruction writes `rd`.
- `dec_is_load`  in  1: the decode instruction is a load.
- `flush`  in  1: branch redirect; kills the instruction in decode.
- `fwd_a_sel`, `fwd_b_sel`  out  2: operand mux selects for the EX-stage instruction.
- `stall`  out  1: hold PC and IF/ID; insert a bubble into ID/EX.
- `stall_cnt`  out  CNT_W: number of stall cycles since reset, saturating.

## Operation
- Select encoding, matching the mux ports:
  - 00: register-file value (a).
  - 01: EX/MEM ALU result (b).
  - 10: MEM/WB writeback data (c).
  - 11: never driven.
- Internal tracking is a 3-deep shift pipeline of {valid, rd, we, is_load}, stages EX, MEM and WB. It advances every cycle.
- EX-stage entry load:
  - Loads {dec_valid & ~stall & ~flush, dec_rd, dec_we, dec_is_load}.
  - When `stall` or `flush` is high, a bubble with valid=0 enters.
- A producer matches a source when all hold: valid, we, rd != 0, rd == rs, and the source is used.
- Select computation happens as the instruction moves from ID to EX, against the stage it will be forwarded from:
  - Match in the EX entry (becomes MEM next cycle): select 01.
  - Otherwise, match in the MEM entry (becomes WB next cycle): select 10.
  - Otherwise: select 00.
  - The youngest producer always wins.
- The register file is write-through, so a producer in WB while the consumer is in ID needs no forwarding.
- Load-use stall:
  - `stall` = dec_valid & EX-entry valid & is_load & match on either used source.
  - It lasts exactly one cycle per hazard, because after the bubble the load sits in MEM and selects 10.
- `flush` has priority over `stall`. If both are high, `stall` is forced to 0 and a bubble enters.
- `stall_cnt` increments on each cycle with `stall`=1 and holds at all-ones.

## Timing
- Reset values:
  - All tracking entries invalid.
  - `fwd_a_sel`/`fwd_b_sel` = 00.
  - `stall` = 0.
  - `stall_cnt` = 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- The selects are registered: they are valid for the whole cycle the consumer spends in EX, with no combinational path from decode.
- `stall` is combinational from the decode inputs and the EX entry. It is valid in the same cycle.
- On a stall cycle the selects update as for a bubble (00).
- A source register of x0 never matches.

## Configuration
- `FWD_HAZARD_FWD_EN` defined: behaviour as above.
- `FWD_HAZARD_FWD_EN` undefined:
  - Selects are tied to 00.
  - `stall` is raised for any used-source match against a valid writing EX or MEM entry, load or not.
  - `stall` stays high until no such match remains, which is up to 2 consecutive cycles.
  - `stall_cnt` counts every one of these cycles.

## Structure
- Shared package `pipe_pkg` holds:
  - The select constants `SEL_RF=2'b00`, `SEL_EXMEM=2'b01`, `SEL_MEMWB=2'b10`.
  - The `REG_AW` default.
  - The tracking-entry struct.
- One natural sub-module, `src_match`: it compares one source against a tracking entry and returns a match bit. It is instantiated four times: 2 sources × EX/MEM entries.

## Test plan
- `add x3,x1,x2` then `sub x4,x3,x5` back-to-back -> `fwd_a_sel`=01 in the sub's EX cycle; `stall` stays 0.
- Producer of x3, one unrelated instruction, then a consumer with x3 on rs2 -> `fwd_b_sel`=10.
- `lw x6` followed by `add x7,x6,x6` -> `stall`=1 for one cycle, then both selects =10, and `stall_cnt` goes 0→1.
- Producer writes x0 and the consumer reads x0 -> selects 00, no stall.
- Load-use hazard with `flush`=1 in the same cycle -> `stall`=0 and a bubble enters; next cycle selects =00.
- `rst_n` pulled low while `stall`=1 -> `stall`, the selects and `stall_cnt` all go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-mux select codes, register-address width
// and the hazard tracking entry.
package pipe_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] SEL_RF    = 2'b00;
   localparam logic [1:0] SEL_EXMEM = 2'b01;
   localparam logic [1:0] SEL_MEMWB = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              is_load;
   } trk_entry_t;

endpackage

// File: rtl/fwd_hazard_ctrl_src_match.sv
// src_match: flags when one decode source is produced by one in-flight entry.
// Register x0 is hardwired to zero and never counts as a producer.
module src_match
   import pipe_pkg::*;
#(
   parameter int AW = REG_AW
) (
   input  logic          prod_valid,
   input  logic          prod_we,
   input  logic [AW-1:0] prod_rd,
   input  logic [AW-1:0] src,
   input  logic          src_used,
   output logic          hit
);

   assign hit = src_used & prod_valid & prod_we & (prod_rd != '0) & (prod_rd == src);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Build option FWD_HAZARD_FWD_EN enables forwarding; without it every RAW hazard stalls.
module fwd_hazard_ctrl #(
   parameter int REG_AW = pipe_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic              dec_rs1_used,
   input  logic              dec_rs2_used,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_we,
   input  logic              dec_is_load,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt
);
   import pipe_pkg::*;

`ifdef FWD_HAZARD_FWD_EN
   localparam logic STALL_ALL = 1'b0;
`else
   localparam logic STALL_ALL = 1'b1;
`endif

   trk_entry_t        ex_q, ex_d;
   // The WB entry is never consulted (write-through register file), and the
   // MEM entry's load flag is never needed, so only the live fields are kept.
   logic              mem_valid_q, mem_valid_d;
   logic              mem_we_q, mem_we_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              stall_d, issue;
   logic              hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;

   src_match #(.AW(REG_AW)) u_match_ex_a (
      .prod_valid(ex_q.valid), .prod_we(ex_q.we), .prod_rd(ex_q.rd),
      .src(dec_rs1), .src_used(dec_rs1_used), .hit(hit_ex_a));

   src_match #(.AW(REG_AW)) u_match_ex_b (
      .prod_valid(ex_q.valid), .prod_we(ex_q.we), .prod_rd(ex_q.rd),
      .src(dec_rs2), .src_used(dec_rs2_used), .hit(hit_ex_b));

   src_match #(.AW(REG_AW)) u_match_mem_a (
      .prod_valid(mem_valid_q), .prod_we(mem_we_q), .prod_rd(mem_rd_q),
      .src(dec_rs1), .src_used(dec_rs1_used), .hit(hit_mem_a));

   src_match #(.AW(REG_AW)) u_match_mem_b (
      .prod_valid(mem_valid_q), .prod_we(mem_we_q), .prod_rd(mem_rd_q),
      .src(dec_rs2), .src_used(dec_rs2_used), .hit(hit_mem_b));

   always_comb begin
      stall_d = 1'b0;
      if (dec_valid && !flush) begin
         stall_d = ((hit_ex_a | hit_ex_b) & (ex_q.is_load | STALL_ALL)) |
                   ((hit_mem_a | hit_mem_b) & STALL_ALL);
      end
      issue = dec_valid & ~stall_d & ~flush;

      ex_d         = '0;
      ex_d.valid   = issue;
      ex_d.rd      = dec_rd;
      ex_d.we      = dec_we;
      ex_d.is_load = dec_is_load;

      mem_valid_d = ex_q.valid;
      mem_we_d    = ex_q.we;
      mem_rd_d    = ex_q.rd;

      stall_cnt_d = stall_cnt_q;
      if (stall_d && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_rd_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_rd_q    <= mem_rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef FWD_HAZARD_FWD_EN
   logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
   logic [1:0] fwd_b_sel_q, fwd_b_sel_d;

   // Youngest producer wins: the current EX entry is checked before MEM.
   always_comb begin
      fwd_a_sel_d = SEL_RF;
      fwd_b_sel_d = SEL_RF;
      if (issue) begin
         if (hit_ex_a)       fwd_a_sel_d = SEL_EXMEM;
         else if (hit_mem_a) fwd_a_sel_d = SEL_MEMWB;
         if (hit_ex_b)       fwd_b_sel_d = SEL_EXMEM;
         else if (hit_mem_b) fwd_b_sel_d = SEL_MEMWB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_sel_q <= SEL_RF;
         fwd_b_sel_q <= SEL_RF;
      end else begin
         fwd_a_sel_q <= fwd_a_sel_d;
         fwd_b_sel_q <= fwd_b_sel_d;
      end
   end

   assign fwd_a_sel = fwd_a_sel_q;
   assign fwd_b_sel = fwd_b_sel_q;
`else
   assign fwd_a_sel = SEL_RF;
   assign fwd_b_sel = SEL_RF;
`endif

   assign stall     = stall_d;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl; expectations follow FWD_HAZARD_FWD_EN.
module tb_fwd_hazard_ctrl;

`ifdef FWD_HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk, rst_n;
   logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_we, dec_is_load, flush;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        stall;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
      .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
      .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall(stall), .stall_cnt(stall_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: instructions issued 1 and 2 cycles ago (distance from the decode slot).
   typedef struct packed {logic v; logic [4:0] rd; logic we; logic ld;} ment_t;
   ment_t       dist1, dist2;
   logic [1:0]  exp_a, exp_b;
   logic [15:0] exp_cnt;

   function automatic bit produces(ment_t e, logic [4:0] rs, logic used);
      return used && (rs != 5'd0) && e.v && e.we && (e.rd == rs);
   endfunction

   function automatic bit m_stall();
      bit near, far;
      near = produces(dist1, dec_rs1, dec_rs1_used) || produces(dist1, dec_rs2, dec_rs2_used);
      far  = produces(dist2, dec_rs1, dec_rs1_used) || produces(dist2, dec_rs2, dec_rs2_used);
      if (!dec_valid || flush) return 1'b0;
      if (FWD) return near && dist1.ld;
      return near || far;
   endfunction

   function automatic logic [1:0] m_sel(logic [4:0] rs, logic used);
      if (!FWD) return 2'b00;
      if (produces(dist1, rs, used)) return 2'b01;
      if (produces(dist2, rs, used)) return 2'b10;
      return 2'b00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dist1   <= '0;
         dist2   <= '0;
         exp_a   <= 2'b00;
         exp_b   <= 2'b00;
         exp_cnt <= 16'd0;
      end else begin
         dist2 <= dist1;
         dist1 <= (dec_valid && !m_stall() && !flush) ? {1'b1, dec_rd, dec_we, dec_is_load} : '0;
         exp_a <= (dec_valid && !m_stall() && !flush) ? m_sel(dec_rs1, dec_rs1_used) : 2'b00;
         exp_b <= (dec_valid && !m_stall() && !flush) ? m_sel(dec_rs2, dec_rs2_used) : 2'b00;
         if (m_stall() && exp_cnt != 16'hFFFF) exp_cnt <= exp_cnt + 16'd1;
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp();
      check("stall", 32'(stall), 32'(m_stall()));
      check("fwd_a_sel", 32'(fwd_a_sel), 32'(exp_a));
      check("fwd_b_sel", 32'(fwd_b_sel), 32'(exp_b));
      check("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
   endtask

   // Presents one instruction, holding it in decode while stalled.
   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic we,
                        input logic ld, output int nst);
      bit done;
      dec_valid = 1'b1; flush = 1'b0;
      dec_rs1 = rs1; dec_rs2 = rs2; dec_rs1_used = u1; dec_rs2_used = u2;
      dec_rd = rd; dec_we = we; dec_is_load = ld;
      nst = 0;
      done = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
         @(negedge clk);
         cmp();
         if (m_stall()) nst++;
         else done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL issue_bound: still stalled after 4 cycles, required release");
      end
      dec_valid = 1'b0;
   endtask

   task automatic drain();
      dec_valid = 1'b0; flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cmp();
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0; dec_valid = 1'b0; flush = 1'b0;
      dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
      dec_rd = '0; dec_we = 1'b0; dec_is_load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(stall), 0);
      check("rst_sel_a", 32'(fwd_a_sel), 0);
      check("rst_sel_b", 32'(fwd_b_sel), 0);
      check("rst_cnt", 32'(stall_cnt), 0);
      rst_n = 1'b1;
      drain();

      // add x3,x1,x2 ; sub x4,x3,x5
      issue(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, n);
      issue(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, n);
      check("t1_nstall", n, FWD ? 0 : 2);
      check("t1_sel_a", 32'(fwd_a_sel), FWD ? 1 : 0);
      check("t1_sel_b", 32'(fwd_b_sel), 0);
      check("t1_cnt", 32'(stall_cnt), FWD ? 0 : 2);
      drain();

      // producer x3, unrelated, consumer on rs2
      issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, n);
      issue(5'd9, 5'd10, 1, 1, 5'd11, 1, 0, n);
      issue(5'd12, 5'd3, 1, 1, 5'd13, 1, 0, n);
      check("t2_nstall", n, FWD ? 0 : 1);
      check("t2_sel_a", 32'(fwd_a_sel), 0);
      check("t2_sel_b", 32'(fwd_b_sel), FWD ? 2 : 0);
      check("t2_cnt", 32'(stall_cnt), FWD ? 0 : 3);
      drain();

      // lw x6 ; add x7,x6,x6
      issue(5'd1, 5'd0, 1, 0, 5'd6, 1, 1, n);
      issue(5'd6, 5'd6, 1, 1, 5'd7, 1, 0, n);
      check("t3_nstall", n, FWD ? 1 : 2);
      check("t3_sel_a", 32'(fwd_a_sel), FWD ? 2 : 0);
      check("t3_sel_b", 32'(fwd_b_sel), FWD ? 2 : 0);
      check("t3_cnt", 32'(stall_cnt), FWD ? 1 : 5);
      drain();

      // x0 producer and consumer
      issue(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, n);
      issue(5'd0, 5'd0, 1, 1, 5'd5, 1, 0, n);
      check("t4_nstall", n, 0);
      check("t4_sel_a", 32'(fwd_a_sel), 0);
      check("t4_sel_b", 32'(fwd_b_sel), 0);
      check("t4_cnt", 32'(stall_cnt), FWD ? 1 : 5);
      drain();

      // load-use hazard killed by flush
      issue(5'd1, 5'd0, 1, 0, 5'd6, 1, 1, n);
      dec_valid = 1'b1; flush = 1'b1;
      dec_rs1 = 5'd6; dec_rs2 = 5'd6; dec_rs1_used = 1'b1; dec_rs2_used = 1'b1;
      dec_rd = 5'd7; dec_we = 1'b1; dec_is_load = 1'b0;
      @(negedge clk);
      cmp();
      check("t5_flush_stall", 32'(stall), 0);
      @(posedge clk); #1;
      check("t5_bubble_sel_a", 32'(fwd_a_sel), 0);
      check("t5_bubble_sel_b", 32'(fwd_b_sel), 0);
      issue(5'd6, 5'd6, 1, 1, 5'd7, 1, 0, n);
      check("t5_nstall", n, FWD ? 0 : 1);
      check("t5_sel_a", 32'(fwd_a_sel), FWD ? 2 : 0);
      check("t5_cnt", 32'(stall_cnt), FWD ? 1 : 6);
      drain();

      // reset asserted while a load-use stall is active
      issue(5'd0, 5'd0, 0, 0, 5'd8, 1, 0, n);
      issue(5'd8, 5'd0, 1, 0, 5'd6, 1, 1, n);
      dec_valid = 1'b1; flush = 1'b0;
      dec_rs1 = 5'd6; dec_rs2 = 5'd6; dec_rs1_used = 1'b1; dec_rs2_used = 1'b1;
      dec_rd = 5'd7; dec_we = 1'b1; dec_is_load = 1'b0;
      @(negedge clk);
      cmp();
      check("t6_pre_stall", 32'(stall), 1);
      check("t6_pre_sel_a", 32'(fwd_a_sel), FWD ? 1 : 0);
      check("t6_pre_cnt", 32'(stall_cnt), FWD ? 1 : 8);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_stall", 32'(stall), 0);
      check("t6_rst_sel_a", 32'(fwd_a_sel), 0);
      check("t6_rst_sel_b", 32'(fwd_b_sel), 0);
      check("t6_rst_cnt", 32'(stall_cnt), 0);
      dec_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
